// File: rtl/aha_tlx_pkg.sv
// rtl/aha_tlx_pkg.sv - shared types for the TLX receive training lane
package aha_tlx_pkg;

  localparam int TLX_SEQ_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    CHECK  = 2'd2,
    FINISH = 2'd3
  } tlx_rx_state_e;

endpackage

// File: rtl/aha_tlx_input_lane_if.sv
// rtl/aha_tlx_input_lane_if.sv - control, data and status bundle of one TLX input lane
interface aha_tlx_input_lane_if #(
  parameter int ERR_W = 16
);
  import aha_tlx_pkg::*;

  logic                 d_in;
  logic                 start;
  logic                 clear;
  logic [TLX_SEQ_W-1:0] seq_word;
  logic [31:0]          length;
  logic                 auto_stop;
  logic                 mode;
  logic                 d_out;
  logic                 active;
  logic                 aligned;
  logic                 done;
  logic                 timeout;
  logic [ERR_W-1:0]     err_count;
  logic [31:0]          word_count;

  modport master (
    output d_in, start, clear, seq_word, length, auto_stop, mode,
    input  d_out, active, aligned, done, timeout, err_count, word_count
  );

  modport slave (
    input  d_in, start, clear, seq_word, length, auto_stop, mode,
    output d_out, active, aligned, done, timeout, err_count, word_count
  );

endinterface

// File: rtl/aha_tlx_rx_edge_det.sv
// rtl/aha_tlx_rx_edge_det.sv - registered rising-edge detector for a register-block level
module aha_tlx_rx_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise_pulse
);

  logic prev_q, prev_d;
  logic rise_q, rise_d;

  always_comb begin
    prev_d = level;
    rise_d = level & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      rise_q <= rise_d;
    end
  end

  assign rise_pulse = rise_q;

endmodule

// File: rtl/aha_tlx_input_lane.sv
// rtl/aha_tlx_input_lane.sv - receive training lane: word lock, bit-error counting, pass-through
module aha_tlx_input_lane
  import aha_tlx_pkg::*;
#(
  parameter int SEARCH_TIMEOUT = 4096,
  parameter int ERR_W          = 16
) (
  input  logic              clk,
  input  logic              reset,
  aha_tlx_input_lane_if.slave lane
);

  localparam int CNT_W = $clog2(SEARCH_TIMEOUT);

  tlx_rx_state_e        state_q, state_d;
  logic [TLX_SEQ_W-1:0] sh_q, sh_d;
  logic [4:0]           idx_q, idx_d;
  logic [CNT_W-1:0]     search_cnt_q, search_cnt_d;
  logic                 aligned_q, aligned_d;
  logic                 done_q, done_d;
  logic                 timeout_q, timeout_d;
  logic [ERR_W-1:0]     err_count_q, err_count_d;
  logic [31:0]          word_count_q, word_count_d;

  logic                 start_p;
  logic                 clear_p;
  logic [TLX_SEQ_W-1:0] sh_next;

  aha_tlx_rx_edge_det u_start_edge (
    .clk        (clk),
    .reset      (reset),
    .level      (lane.start),
    .rise_pulse (start_p)
  );

  aha_tlx_rx_edge_det u_clear_edge (
    .clk        (clk),
    .reset      (reset),
    .level      (lane.clear),
    .rise_pulse (clear_p)
  );

  // Incoming bits enter at the MSB so that after 32 shifts bit 0 of the word sits at sh[0].
  assign sh_next = {lane.d_in, sh_q[TLX_SEQ_W-1:1]};

  always_comb begin
    state_d      = state_q;
    sh_d         = sh_q;
    idx_d        = idx_q;
    search_cnt_d = search_cnt_q;
    aligned_d    = aligned_q;
    done_d       = done_q;
    timeout_d    = timeout_q;
    err_count_d  = err_count_q;
    word_count_d = word_count_q;

    if (clear_p) begin
      state_d      = IDLE;
      sh_d         = '0;
      idx_d        = '0;
      search_cnt_d = '0;
      aligned_d    = 1'b0;
      done_d       = 1'b0;
      timeout_d    = 1'b0;
      err_count_d  = '0;
      word_count_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_p) begin
            state_d      = SEARCH;
            sh_d         = '0;
            search_cnt_d = '0;
            aligned_d    = 1'b0;
            done_d       = 1'b0;
            timeout_d    = 1'b0;
            err_count_d  = '0;
            word_count_d = '0;
          end
        end
        SEARCH: begin
          sh_d         = sh_next;
          search_cnt_d = search_cnt_q + CNT_W'(1);
          if (search_cnt_q >= CNT_W'(31) && sh_next == lane.seq_word) begin
            aligned_d    = 1'b1;
            word_count_d = 32'd1;
            idx_d        = '0;
            if (lane.auto_stop && lane.length <= 32'd1) begin
              done_d  = 1'b1;
              state_d = FINISH;
            end else begin
              state_d = CHECK;
            end
          end else if (search_cnt_q == CNT_W'(SEARCH_TIMEOUT - 1)) begin
            timeout_d = 1'b1;
            state_d   = IDLE;
          end
        end
        CHECK: begin
          if (lane.d_in != lane.seq_word[idx_q] && err_count_q != '1) begin
            err_count_d = err_count_q + ERR_W'(1);
          end
          idx_d = idx_q + 5'd1;
          if (idx_q == 5'd31) begin
            word_count_d = word_count_q + 32'd1;
            if (lane.auto_stop && word_count_q + 32'd1 == lane.length) begin
              done_d  = 1'b1;
              state_d = FINISH;
            end
          end
        end
        FINISH: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      sh_q         <= '0;
      idx_q        <= '0;
      search_cnt_q <= '0;
      aligned_q    <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      err_count_q  <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      sh_q         <= sh_d;
      idx_q        <= idx_d;
      search_cnt_q <= search_cnt_d;
      aligned_q    <= aligned_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      err_count_q  <= err_count_d;
      word_count_q <= word_count_d;
    end
  end

  assign lane.active     = (state_q == SEARCH) || (state_q == CHECK);
  assign lane.d_out      = lane.mode ? 1'b0 : lane.d_in;
  assign lane.aligned    = aligned_q;
  assign lane.done       = done_q;
  assign lane.timeout    = timeout_q;
  assign lane.err_count  = err_count_q;
  assign lane.word_count = word_count_q;

endmodule
